// File: rtl/wb_mem_2_ppfifo_pkg.sv
// Shared types and constants for the memory-to-ppfifo read DMA.
package wb_mem_2_ppfifo_pkg;

  localparam logic [3:0] WB_SEL = 4'hF;
  localparam int REGION_IDX_W = 1;

  typedef logic [REGION_IDX_W-1:0] region_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GET_FIFO,
    ST_READ,
    ST_WRITE
  } dma_state_t;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_BUS,
    RD_ACK_LOW
  } rd_state_t;

endpackage

// File: rtl/wb_mem_2_ppfifo_if.sv
// Wishbone master bus plus ppfifo write side, seen from the DMA engine (master) and the fabric (slave).
interface wb_mem_2_ppfifo_if;

  logic        mem_we;
  logic        mem_stb;
  logic        mem_cyc;
  logic [3:0]  mem_sel;
  logic [31:0] mem_adr;
  logic [31:0] mem_wr_dat;
  logic [31:0] mem_rd_dat;
  logic        mem_ack;
  logic        mem_int;

  logic [1:0]  ppfifo_rdy;
  logic [1:0]  ppfifo_act;
  logic [23:0] ppfifo_size;
  logic        ppfifo_stb;
  logic [31:0] ppfifo_data;

  modport master (
    output mem_we, mem_stb, mem_cyc, mem_sel, mem_adr, mem_wr_dat,
    input  mem_rd_dat, mem_ack, mem_int,
    output ppfifo_act, ppfifo_stb, ppfifo_data,
    input  ppfifo_rdy, ppfifo_size
  );

  modport slave (
    input  mem_we, mem_stb, mem_cyc, mem_sel, mem_adr, mem_wr_dat,
    output mem_rd_dat, mem_ack, mem_int,
    input  ppfifo_act, ppfifo_stb, ppfifo_data,
    output ppfifo_rdy, ppfifo_size
  );

endinterface

// File: rtl/wb_mem_2_ppfifo_wb_single_read.sv
// One classic Wishbone read: latch address on start, hold cyc/stb until ack, capture data.
// Latency: stb one cycle after start; done pulses the first cycle ack is seen low after the ack.
// Backpressure: waits indefinitely for ack and for ack release; start is ignored while busy.
module wb_mem_2_ppfifo_wb_single_read
  import wb_mem_2_ppfifo_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] adr,
  output logic        done,
  output logic [31:0] dat,
  output logic        cyc,
  output logic        stb,
  output logic [31:0] mem_adr,
  input  logic [31:0] mem_dat,
  input  logic        mem_ack
);

  rd_state_t state, state_nxt;

  always_ff @(posedge clk) begin
    if (rst) state <= RD_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    cyc       = 1'b0;
    stb       = 1'b0;
    case (state)
      RD_IDLE: if (start) state_nxt = RD_BUS;
      RD_BUS: begin
        cyc = 1'b1;
        stb = 1'b1;
        if (mem_ack) state_nxt = RD_ACK_LOW;
      end
      RD_ACK_LOW: begin
        // a slave may hold ack after stb drops; never re-strobe until it lets go
        if (!mem_ack) begin
          done      = 1'b1;
          state_nxt = RD_IDLE;
        end
      end
      default: state_nxt = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_adr <= '0;
      dat     <= '0;
    end else begin
      if (state == RD_IDLE && start) mem_adr <= adr;
      if (state == RD_BUS && mem_ack) dat <= mem_dat;
    end
  end

endmodule

// File: rtl/wb_mem_2_ppfifo.sv
// Ping-pong memory-to-ppfifo DMA: reads two armed regions over Wishbone into ppfifo halves.
// Latency: one word per >=4 clocks (read issue, bus, ack release, fifo strobe).
// Backpressure: stalls in GET_FIFO until a ppfifo half is ready; i_enable low parks after the current word.
module wb_mem_2_ppfifo
  import wb_mem_2_ppfifo_pkg::*;
#(
  parameter logic [31:0] DEFAULT_MEM_0_BASE = 32'h0000_0000,
  parameter logic [31:0] DEFAULT_MEM_1_BASE = 32'h0010_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_enable,
  input  logic [31:0] i_memory_0_base,
  input  logic [31:0] i_memory_0_size,
  input  logic        i_memory_0_ready,
  output logic [31:0] o_memory_0_count,
  output logic        o_memory_0_finished,
  output logic        o_memory_0_empty,
  input  logic [31:0] i_memory_1_base,
  input  logic [31:0] i_memory_1_size,
  input  logic        i_memory_1_ready,
  output logic [31:0] o_memory_1_count,
  output logic        o_memory_1_finished,
  output logic        o_memory_1_empty,
  output logic [31:0] o_default_mem_0_base,
  output logic [31:0] o_default_mem_1_base,
  output logic        o_read_finished,
  wb_mem_2_ppfifo_if.master bus
);

  dma_state_t       state, state_nxt;
  region_t          cur_q;
  logic [1:0][31:0] base_q, size_q, count_q, arm_base, arm_size;
  logic [1:0]       finished_q, empty_q, arm_rdy, arm_ok, act_q;
  logic [23:0]      fifo_cnt_q;
  logic             read_finished_q;
  logic             grant, release_act, do_word, pick_other, rd_start, rd_done;
  logic             region_done, other_pending, fifo_full;
  logic [31:0]      cnt_inc, rd_adr, rd_dat;
  logic             unused_int;

  assign arm_base = {i_memory_1_base, i_memory_0_base};
  assign arm_size = {i_memory_1_size, i_memory_0_size};
  assign arm_rdy  = {i_memory_1_ready, i_memory_0_ready};

  assign cnt_inc       = count_q[cur_q] + 32'd1;
  assign region_done   = (cnt_inc == size_q[cur_q]);
  assign other_pending = !empty_q[~cur_q];
  assign fifo_full     = ((fifo_cnt_q + 24'd1) == bus.ppfifo_size);
  assign rd_adr        = base_q[cur_q] + count_q[cur_q];

  always_comb begin
    for (int n = 0; n < 2; n++) begin
      arm_ok[n] = arm_rdy[n] && (arm_size[n] != 32'd0) &&
                  !((state != ST_IDLE) && (cur_q == region_t'(n)) && !empty_q[n]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    grant       = 1'b0;
    release_act = 1'b0;
    do_word     = 1'b0;
    pick_other  = 1'b0;
    rd_start    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_enable && (empty_q != 2'b11)) begin
          pick_other = empty_q[cur_q];
          state_nxt  = ST_GET_FIFO;
        end
      end
      ST_GET_FIFO: begin
        if (!i_enable) begin
          state_nxt = ST_IDLE;
        end else if (bus.ppfifo_rdy != 2'b00) begin
          grant     = 1'b1;
          state_nxt = ST_READ;
        end
      end
      ST_READ: begin
        rd_start = 1'b1;
        if (rd_done) state_nxt = ST_WRITE;
      end
      ST_WRITE: begin
        do_word    = 1'b1;
        pick_other = region_done && other_pending;
        // the fifo half is kept across a region switch; only released when full or parking
        if ((region_done && !other_pending) || !i_enable) begin
          release_act = 1'b1;
          state_nxt   = ST_IDLE;
        end else if (fifo_full) begin
          release_act = 1'b1;
          state_nxt   = ST_GET_FIFO;
        end else begin
          state_nxt = ST_READ;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_q           <= '0;
      base_q          <= '0;
      size_q          <= '0;
      count_q         <= '0;
      finished_q      <= '0;
      empty_q         <= 2'b11;
      act_q           <= '0;
      fifo_cnt_q      <= '0;
      read_finished_q <= 1'b0;
    end else begin
      read_finished_q <= 1'b0;
      for (int n = 0; n < 2; n++) begin
        if (arm_ok[n]) begin
          base_q[n]     <= arm_base[n];
          size_q[n]     <= arm_size[n];
          count_q[n]    <= '0;
          finished_q[n] <= 1'b0;
          empty_q[n]    <= 1'b0;
        end
      end
      if (pick_other) cur_q <= ~cur_q;
      if (grant) begin
        act_q      <= bus.ppfifo_rdy[0] ? 2'b01 : 2'b10;
        fifo_cnt_q <= '0;
      end
      if (do_word) begin
        count_q[cur_q] <= cnt_inc;
        fifo_cnt_q     <= fifo_cnt_q + 24'd1;
        if (region_done) begin
          finished_q[cur_q] <= 1'b1;
          empty_q[cur_q]    <= 1'b1;
          read_finished_q   <= 1'b1;
        end
      end
      if (release_act) begin
        act_q      <= '0;
        fifo_cnt_q <= '0;
      end
    end
  end

  wb_mem_2_ppfifo_wb_single_read u_rd (
    .clk     (clk),
    .rst     (rst),
    .start   (rd_start),
    .adr     (rd_adr),
    .done    (rd_done),
    .dat     (rd_dat),
    .cyc     (bus.mem_cyc),
    .stb     (bus.mem_stb),
    .mem_adr (bus.mem_adr),
    .mem_dat (bus.mem_rd_dat),
    .mem_ack (bus.mem_ack)
  );

  assign bus.mem_we      = 1'b0;
  assign bus.mem_sel     = WB_SEL;
  assign bus.mem_wr_dat  = '0;
  assign bus.ppfifo_act  = act_q;
  assign bus.ppfifo_stb  = do_word;
  assign bus.ppfifo_data = rd_dat;
  assign unused_int      = bus.mem_int;

  assign o_memory_0_count     = count_q[0];
  assign o_memory_1_count     = count_q[1];
  assign o_memory_0_finished  = finished_q[0];
  assign o_memory_1_finished  = finished_q[1];
  assign o_memory_0_empty     = empty_q[0];
  assign o_memory_1_empty     = empty_q[1];
  assign o_default_mem_0_base = DEFAULT_MEM_0_BASE;
  assign o_default_mem_1_base = DEFAULT_MEM_1_BASE;
  assign o_read_finished      = read_finished_q;

endmodule

// File: tb/tb_wb_mem_2_ppfifo.sv
// Scoreboard bench: stimulus queues expected read addresses and ppfifo words, monitors compare on the fly.
module tb_wb_mem_2_ppfifo;
  import wb_mem_2_ppfifo_pkg::*;

  logic        clk, rst, i_enable;
  logic [31:0] i_memory_0_base, i_memory_0_size, i_memory_1_base, i_memory_1_size;
  logic        i_memory_0_ready, i_memory_1_ready;
  logic [31:0] o_memory_0_count, o_memory_1_count, o_default_mem_0_base, o_default_mem_1_base;
  logic        o_memory_0_finished, o_memory_1_finished, o_memory_0_empty, o_memory_1_empty;
  logic        o_read_finished;

  wb_mem_2_ppfifo_if bus ();

  wb_mem_2_ppfifo dut (
    .clk                 (clk),
    .rst                 (rst),
    .i_enable            (i_enable),
    .i_memory_0_base     (i_memory_0_base),
    .i_memory_0_size     (i_memory_0_size),
    .i_memory_0_ready    (i_memory_0_ready),
    .o_memory_0_count    (o_memory_0_count),
    .o_memory_0_finished (o_memory_0_finished),
    .o_memory_0_empty    (o_memory_0_empty),
    .i_memory_1_base     (i_memory_1_base),
    .i_memory_1_size     (i_memory_1_size),
    .i_memory_1_ready    (i_memory_1_ready),
    .o_memory_1_count    (o_memory_1_count),
    .o_memory_1_finished (o_memory_1_finished),
    .o_memory_1_empty    (o_memory_1_empty),
    .o_default_mem_0_base(o_default_mem_0_base),
    .o_default_mem_1_base(o_default_mem_1_base),
    .o_read_finished     (o_read_finished),
    .bus                 (bus)
  );

  int          checks = 0;
  int          failures = 0;
  int          ack_hold = 0;
  int          stb_rises = 0;
  int          rf_pulses = 0;
  int          half_words = 0;
  logic [31:0] exp_adr[$];
  logic [31:0] exp_dat[$];
  int          halves[$];
  logic [1:0]  exp_act = 2'b01;
  logic [31:0] watch_adr = '0;
  logic        prev_stb = 1'b0;
  logic [1:0]  prev_act = 2'b00;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  function automatic bit cond(input int sel);
    case (sel)
      0:       return o_memory_0_finished;
      1:       return o_memory_1_finished;
      default: return bus.mem_stb && (bus.mem_adr == watch_adr);
    endcase
  endfunction

  task automatic wait_cond(input int sel, input int budget, input string name);
    int n = 0;
    while (!cond(sel) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!cond(sel)) begin
      failures++;
      $display("FAIL timeout_%s: not reached within %0d cycles", name, budget);
    end
  endtask

  task automatic expect_words(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      exp_adr.push_back(base + 32'(i));
      exp_dat.push_back(mem_word(base + 32'(i)));
    end
  endtask

  task automatic arm(input int region, input logic [31:0] base, input logic [31:0] size);
    if (region == 0) begin
      i_memory_0_base = base; i_memory_0_size = size; i_memory_0_ready = 1'b1;
    end else begin
      i_memory_1_base = base; i_memory_1_size = size; i_memory_1_ready = 1'b1;
    end
    @(negedge clk);
    i_memory_0_ready = 1'b0;
    i_memory_1_ready = 1'b0;
  endtask

  // Wishbone slave: registered ack, optionally held for ack_hold cycles after stb drops
  initial begin
    int hold;
    hold = 0;
    bus.mem_ack    = 1'b0;
    bus.mem_rd_dat = '0;
    bus.mem_int    = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!bus.mem_ack && bus.mem_stb && bus.mem_cyc) begin
        bus.mem_ack    = 1'b1;
        bus.mem_rd_dat = mem_word(bus.mem_adr);
        hold = 0;
      end else if (bus.mem_ack && !bus.mem_stb) begin
        if (hold >= ack_hold) bus.mem_ack = 1'b0;
        else hold++;
      end
    end
  end

  // monitor: each new strobe and each ppfifo write is checked against the queues
  initial begin
    forever begin
      @(negedge clk);
      if (bus.mem_stb && !prev_stb) begin
        stb_rises++;
        if (exp_adr.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_read: adr %h with none expected", bus.mem_adr);
        end else check("read_adr", bus.mem_adr, exp_adr.pop_front());
      end
      prev_stb = bus.mem_stb;
      if (bus.ppfifo_stb) begin
        half_words++;
        if (exp_dat.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_write: data %h with none expected", bus.ppfifo_data);
        end else check("fifo_data", bus.ppfifo_data, exp_dat.pop_front());
        check("fifo_act", 32'(bus.ppfifo_act), 32'(exp_act));
      end
      if (prev_act != 2'b00 && bus.ppfifo_act == 2'b00) begin
        halves.push_back(half_words);
        half_words = 0;
      end
      prev_act = bus.ppfifo_act;
      if (o_read_finished) rf_pulses++;
    end
  end

  initial begin
    int rises0;
    rst = 1'b1; i_enable = 1'b0;
    i_memory_0_base = '0; i_memory_0_size = '0; i_memory_0_ready = 1'b0;
    i_memory_1_base = '0; i_memory_1_size = '0; i_memory_1_ready = 1'b0;
    bus.ppfifo_rdy = 2'b00; bus.ppfifo_size = 24'd8;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_empty0", 32'(o_memory_0_empty), 32'd1);
    check("rst_empty1", 32'(o_memory_1_empty), 32'd1);
    check("rst_count0", o_memory_0_count, 32'd0);
    check("rst_fin0", 32'(o_memory_0_finished), 32'd0);
    check("rst_cyc", 32'(bus.mem_cyc), 32'd0);
    check("rst_act", 32'(bus.ppfifo_act), 32'd0);
    check("def_base0", o_default_mem_0_base, 32'h0000_0000);
    check("def_base1", o_default_mem_1_base, 32'h0010_0000);

    // single short region, partial half released
    bus.ppfifo_rdy = 2'b01; i_enable = 1'b1;
    expect_words(32'h100, 4);
    arm(0, 32'h100, 32'd4);
    wait_cond(0, 200, "t1_fin");
    repeat (5) @(negedge clk);
    check("t1_count0", o_memory_0_count, 32'd4);
    check("t1_fin0", 32'(o_memory_0_finished), 32'd1);
    check("t1_empty0", 32'(o_memory_0_empty), 32'd1);
    check("t1_act", 32'(bus.ppfifo_act), 32'd0);
    check("t1_rf", 32'(rf_pulses), 32'd1);

    // both regions armed together, halves of 8 spanning the switch
    expect_words(32'h200, 10);
    expect_words(32'h300, 6);
    i_memory_0_base = 32'h200; i_memory_0_size = 32'd10; i_memory_0_ready = 1'b1;
    i_memory_1_base = 32'h300; i_memory_1_size = 32'd6;  i_memory_1_ready = 1'b1;
    @(negedge clk);
    i_memory_0_ready = 1'b0; i_memory_1_ready = 1'b0;
    wait_cond(1, 500, "t2_fin");
    repeat (5) @(negedge clk);
    check("t2_count0", o_memory_0_count, 32'd10);
    check("t2_count1", o_memory_1_count, 32'd6);
    check("t2_rf", 32'(rf_pulses), 32'd3);
    check("halves_n", 32'(halves.size()), 32'd3);
    if (halves.size() == 3) begin
      check("half0", 32'(halves[0]), 32'd4);
      check("half1", 32'(halves[1]), 32'd8);
      check("half2", 32'(halves[2]), 32'd8);
    end

    // slave holds ack after stb drops
    ack_hold = 3;
    expect_words(32'h400, 3);
    arm(0, 32'h400, 32'd3);
    wait_cond(0, 300, "t3_fin");
    repeat (8) @(negedge clk);
    check("t3_count0", o_memory_0_count, 32'd3);
    check("t3_pending", 32'(exp_dat.size()), 32'd0);
    ack_hold = 0;

    // address wrap, upper half of the fifo
    bus.ppfifo_rdy = 2'b10; exp_act = 2'b10;
    expect_words(32'hFFFF_FFFE, 4);
    arm(1, 32'hFFFF_FFFE, 32'd4);
    wait_cond(1, 200, "t4_fin");
    repeat (5) @(negedge clk);
    check("t4_count1", o_memory_1_count, 32'd4);
    bus.ppfifo_rdy = 2'b01; exp_act = 2'b01;

    // enable dropped during the third word
    expect_words(32'h500, 3);
    arm(0, 32'h500, 32'd6);
    watch_adr = 32'h502;
    wait_cond(2, 200, "t5_third");
    i_enable = 1'b0;
    repeat (20) @(negedge clk);
    check("t5_count0", o_memory_0_count, 32'd3);
    check("t5_act", 32'(bus.ppfifo_act), 32'd0);
    check("t5_cyc", 32'(bus.mem_cyc), 32'd0);
    check("t5_fin0", 32'(o_memory_0_finished), 32'd0);
    check("t5_empty0", 32'(o_memory_0_empty), 32'd0);
    expect_words(32'h503, 3);
    i_enable = 1'b1;
    wait_cond(0, 200, "t5_fin");
    repeat (5) @(negedge clk);
    check("t5_count0_end", o_memory_0_count, 32'd6);

    // zero-size arm ignored
    rises0 = stb_rises;
    arm(0, 32'h700, 32'd0);
    repeat (20) @(negedge clk);
    check("t6_no_reads", 32'(stb_rises - rises0), 32'd0);
    check("t6_empty0", 32'(o_memory_0_empty), 32'd1);
    check("t6_fin0", 32'(o_memory_0_finished), 32'd1);

    // reset while the bus read is outstanding
    exp_adr.push_back(32'h600);
    arm(0, 32'h600, 32'd4);
    watch_adr = 32'h600;
    wait_cond(2, 200, "t7_read");
    rst = 1'b1;
    @(negedge clk);
    check("t7_cyc", 32'(bus.mem_cyc), 32'd0);
    check("t7_stb", 32'(bus.mem_stb), 32'd0);
    check("t7_act", 32'(bus.ppfifo_act), 32'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("t7_empty0", 32'(o_memory_0_empty), 32'd1);
    check("t7_count0", o_memory_0_count, 32'd0);
    check("t7_idle_cyc", 32'(bus.mem_cyc), 32'd0);
    check("left_adr", 32'(exp_adr.size()), 32'd0);
    check("left_dat", 32'(exp_dat.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
